// File: rtl/par_shift_reg_pkg.sv
// rtl/par_shift_reg_pkg.sv - direction names and default load values for par_shift_reg
package par_shift_reg_pkg;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  localparam logic [7:0] DEF_LOAD_AVALUE = 8'b0000_0001;
  localparam logic [7:0] DEF_LOAD_SVALUE = 8'b0000_0001;

endpackage

// File: rtl/par_shift_reg_next.sv
// rtl/par_shift_reg_next.sv - next-state mux: aset, then enable-gated sclr/sset/load/shift
module par_shift_reg_next #(
  parameter int              W       = 8,
  parameter bit              IS_LEFT = 1'b0,
  parameter logic [W-1:0]    AVAL    = '0,
  parameter logic [W-1:0]    SVAL    = '0
) (
  input  logic [W-1:0] i_q,
  input  logic         i_aset,
  input  logic         i_enable,
  input  logic         i_sclr,
  input  logic         i_sset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shiftin,
  output logic [W-1:0] o_d
);

  logic [W-1:0] w_shifted;

  if (IS_LEFT) begin : g_left
    assign w_shifted = {i_q[W-2:0], i_shiftin};
  end else begin : g_right
    assign w_shifted = {i_shiftin, i_q[W-1:1]};
  end

  // Nested ifs keep an unknown lower-priority input from leaking into o_d.
  always_comb begin
    o_d = i_q;
    if (i_aset) begin
      o_d = AVAL;
    end else if (i_enable) begin
      if (i_sclr) begin
        o_d = '0;
      end else if (i_sset) begin
        o_d = SVAL;
      end else if (i_load) begin
        o_d = i_data;
      end else begin
        o_d = w_shifted;
      end
    end
  end

endmodule

// File: rtl/par_shift_reg.sv
// rtl/par_shift_reg.sv - W-bit shift register with load/set/clear; checks under PAR_SHIFT_REG_ASSERT_EN
module par_shift_reg
  import par_shift_reg_pkg::*;
#(
  parameter int                     SHIFT_WIDTH     = 8,
  parameter logic [SHIFT_WIDTH-1:0] LOAD_AVALUE     = SHIFT_WIDTH'(DEF_LOAD_AVALUE),
  parameter logic [SHIFT_WIDTH-1:0] LOAD_SVALUE     = SHIFT_WIDTH'(DEF_LOAD_SVALUE),
  parameter string                  SHIFT_DIRECTION = "RIGHT"
) (
  input  logic                   sclr,
  input  logic                   sset,
  input  logic                   shiftin,
  input  logic                   load,
  input  logic [SHIFT_WIDTH-1:0] data,
  input  logic                   clock,
  input  logic                   enable,
  input  logic                   aclr,
  input  logic                   aset,
  output logic                   shiftout,
  output logic [SHIFT_WIDTH-1:0] q
);

  // Anything other than LEFT shifts right.
  localparam bit IS_LEFT = (SHIFT_DIRECTION == DIR_LEFT);

  logic [SHIFT_WIDTH-1:0] r_q;
  logic [SHIFT_WIDTH-1:0] w_d;

  par_shift_reg_next #(
    .W       (SHIFT_WIDTH),
    .IS_LEFT (IS_LEFT),
    .AVAL    (LOAD_AVALUE),
    .SVAL    (LOAD_SVALUE)
  ) u_next (
    .i_q       (r_q),
    .i_aset    (aset),
    .i_enable  (enable),
    .i_sclr    (sclr),
    .i_sset    (sset),
    .i_load    (load),
    .i_data    (data),
    .i_shiftin (shiftin),
    .o_d       (w_d)
  );

  always_ff @(posedge clock) begin
    if (aclr) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign q        = r_q;
  assign shiftout = IS_LEFT ? r_q[SHIFT_WIDTH-1] : r_q[0];

`ifdef PAR_SHIFT_REG_ASSERT_EN
  if (!((SHIFT_DIRECTION == DIR_LEFT) || (SHIFT_DIRECTION == DIR_RIGHT)) || (SHIFT_WIDTH < 2)) begin : g_bad_cfg
    $fatal(1, "par_shift_reg: bad SHIFT_DIRECTION or SHIFT_WIDTH");
  end

  // q is only defined once aclr has been seen.
  logic r_armed;

  always_ff @(posedge clock) begin
    if (aclr) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (r_armed === 1'b1) begin
      assert (!$isunknown(r_q)) else $error("par_shift_reg: q has X/Z");
    end
  end
`endif

endmodule

// File: tb/tb_par_shift_reg.sv
// tb/tb_par_shift_reg.sv - directed plan plus random stimulus against a reference model
module tb_par_shift_reg;

  logic       clk = 1'b0;
  logic       sclr = 1'b0, sset = 1'b0, shiftin = 1'b0, load = 1'b0;
  logic       enable = 1'b0, aclr = 1'b0, aset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       so_r, so_l;
  logic [7:0] q_r, q_l;

  logic [7:0] m_r, m_l;
  int         vectors = 0;
  int         miscompares = 0;

  localparam logic [7:0] R_AVAL = 8'h01, R_SVAL = 8'h01;
  localparam logic [7:0] L_AVAL = 8'hA5, L_SVAL = 8'h3C;

  always #5 clk = ~clk;

  par_shift_reg u_right (
    .sclr(sclr), .sset(sset), .shiftin(shiftin), .load(load), .data(data),
    .clock(clk), .enable(enable), .aclr(aclr), .aset(aset),
    .shiftout(so_r), .q(q_r)
  );

  par_shift_reg #(
    .SHIFT_WIDTH(8), .LOAD_AVALUE(L_AVAL), .LOAD_SVALUE(L_SVAL), .SHIFT_DIRECTION("LEFT")
  ) u_left (
    .sclr(sclr), .sset(sset), .shiftin(shiftin), .load(load), .data(data),
    .clock(clk), .enable(enable), .aclr(aclr), .aset(aset),
    .shiftout(so_l), .q(q_l)
  );

  // Reference: priority list evaluated top-down; shift as arithmetic on the integer value.
  function automatic logic [7:0] model_next(logic [7:0] cur, bit left,
                                            logic [7:0] av, logic [7:0] sv);
    int unsigned v;
    if (aclr)        return 8'h00;
    if (aset)        return av;
    if (!enable)     return cur;
    if (sclr)        return 8'h00;
    if (sset)        return sv;
    if (load)        return data;
    v = cur;
    if (left) v = (v * 2 + (shiftin ? 1 : 0)) % 256;
    else      v = v / 2 + (shiftin ? 128 : 0);
    return 8'(v);
  endfunction

  task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    m_r = model_next(m_r, 1'b0, R_AVAL, R_SVAL);
    m_l = model_next(m_l, 1'b1, L_AVAL, L_SVAL);
    @(posedge clk);
    #1;
    check8({tag, "_qr"}, q_r, m_r);
    check1({tag, "_sor"}, so_r, m_r % 2 == 1);
    check8({tag, "_ql"}, q_l, m_l);
    check1({tag, "_sol"}, so_l, m_l >= 128);
  endtask

  initial begin
    logic [7:0] exp_q [5];
    logic       exp_so [5];
    exp_q  = '{8'hAE, 8'hD7, 8'hEB, 8'hF5, 8'hFA};
    exp_so = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    m_r = 8'h00;
    m_l = 8'h00;
    @(negedge clk);

    shiftin = 1'b1;
    aclr = 1'b1; enable = 1'b1;
    step("reset");
    check8("plan_reset_q", q_r, 8'h00);
    check1("plan_reset_so", so_r, 1'b0);

    aclr = 1'b0; aset = 1'b1;
    step("aset");
    check8("plan_aset_q", q_r, 8'h01);
    check1("plan_aset_so", so_r, 1'b1);
    check8("plan_aset_left", q_l, L_AVAL);

    aset = 1'b0; enable = 1'b0;
    step("hold");
    check8("plan_hold_q", q_r, 8'h01);

    enable = 1'b1; sclr = 1'b1;
    step("sclr");
    check8("plan_sclr_q", q_r, 8'h00);

    sclr = 1'b0; sset = 1'b1;
    step("sset");
    check8("plan_sset_q", q_r, 8'h01);
    check8("plan_sset_left", q_l, L_SVAL);

    sset = 1'b0; load = 1'b1; data = 8'b0101_1101;
    step("load");
    check8("plan_load_q", q_r, 8'h5D);

    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("shift");
      check8("plan_shift_q", q_r, exp_q[i]);
      check1("plan_shift_so", so_r, exp_so[i]);
    end

    sclr = 1'b1; sset = 1'b1; load = 1'b1;
    step("clr_beats_set");
    check8("plan_clr_wins", q_r, 8'h00);
    sclr = 1'b0;
    step("set_beats_load");
    check8("plan_set_wins", q_r, 8'h01);
    sset = 1'b0; load = 1'b0;

    aclr = 1'b1; aset = 1'b1;
    step("aclr_beats_aset");
    check8("plan_aclr_wins", q_r, 8'h00);
    aclr = 1'b0; aset = 1'b0;

    shiftin = 1'b0; load = 1'b1; data = 8'h81;
    step("left_load");
    check8("plan_left_load", q_l, 8'h81);
    load = 1'b0;
    step("left_shift");
    check8("plan_left_shift", q_l, 8'h02);
    check1("plan_left_so", so_l, 1'b0);

    aclr = 1'b1; load = 1'b1; enable = 1'b0;
    step("aclr_mid");
    check8("plan_aclr_mid_left", q_l, 8'h00);
    check8("plan_aclr_mid_right", q_r, 8'h00);

    for (int i = 0; i < 400; i++) begin
      aclr    = ($urandom_range(0, 19) == 0);
      aset    = ($urandom_range(0, 15) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      sclr    = ($urandom_range(0, 7) == 0);
      sset    = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 3) == 0);
      shiftin = 1'($urandom);
      data    = 8'($urandom);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
